// File: rtl/conv_layer_sched.sv
// Layer sequencer for the shared 3x3 conv unit: runs one kernel at a time, streams the
// feature map through the conv unit and writes back only the results of fully in-image windows.
module conv_layer_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int F          = 3,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int N_KERNEL   = 8,
  parameter int PIPE_LAT   = 6,
  parameter int ADDR_W     = 10,
  parameter int OADDR_W    = 13
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            start,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            rd_en,
  output logic [ADDR_W-1:0]                               rd_addr,
  input  logic [DATA_WIDTH-1:0]                           rd_data1,
  input  logic [DATA_WIDTH-1:0]                           rd_data2,
  input  logic [DATA_WIDTH-1:0]                           rd_data3,
  output logic [(N_KERNEL > 1 ? $clog2(N_KERNEL) : 1)-1:0] k_idx,
  output logic                                            conv_clr,
  output logic                                            conv_iValid,
  output logic [DATA_WIDTH-1:0]                           conv_iData1,
  output logic [DATA_WIDTH-1:0]                           conv_iData2,
  output logic [DATA_WIDTH-1:0]                           conv_iData3,
  input  logic [DATA_WIDTH-1:0]                           conv_result,
  output logic                                            out_valid,
  output logic [DATA_WIDTH-1:0]                           out_data,
  output logic [OADDR_W-1:0]                              out_addr
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int KW   = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DW   = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [DW-1:0]       drain_cnt;
  logic                win;
  logic                tag_d;
  logic [PIPE_LAT-1:0] tag_pipe;

  // Pixel currently being read sits at the bottom-right corner of a fully in-image window.
  assign win = (row >= RW'(F - 1)) && (col >= CW'(F - 1));

  // NOTE: every register below is written with <= so all of them see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      conv_clr  <= 1'b0;
      k_idx     <= '0;
      rd_addr   <= '0;
      row       <= '0;
      col       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            busy     <= 1'b1;
            conv_clr <= 1'b1;
          end
        end
        S_LOAD: begin
          conv_clr <= 1'b0;
          rd_en    <= 1'b1;
          rd_addr  <= '0;
          row      <= '0;
          col      <= '0;
          state    <= S_STREAM;
        end
        S_STREAM: begin
          if (rd_addr == ADDR_W'(NPIX - 1)) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            if (col == CW'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Hold until the last window's tag has left the pipe before switching banks.
          if (drain_cnt == DW'(PIPE_LAT)) begin
            if (k_idx == KW'(N_KERNEL - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
              k_idx <= '0;
            end else begin
              state    <= S_LOAD;
              conv_clr <= 1'b1;
              k_idx    <= k_idx + 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pixel data comes straight from the RAM; its valid is the read strobe one cycle late.
  assign conv_iData1 = rd_data1;
  assign conv_iData2 = rd_data2;
  assign conv_iData3 = rd_data3;
  assign out_valid   = tag_pipe[PIPE_LAT-1];
  assign out_data    = conv_result;

  // NOTE: the tag pipe is a handful of flops, not a RAM, so it is reset to flush stale tags on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_iValid <= 1'b0;
      tag_d       <= 1'b0;
      tag_pipe    <= '0;
      out_addr    <= '0;
    end else begin
      conv_iValid <= rd_en;
      tag_d       <= rd_en && win;
      tag_pipe[0] <= tag_d;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
      if (out_valid) begin
        out_addr <= out_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched on a 4x4 image, 2 kernels; the conv unit stub
// echoes the channel-0 pixel (its feature-RAM index) after PIPE_LAT cycles.
module tb_conv_layer_sched;

  localparam int DWID = 16;
  localparam int PL   = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, rd_en, conv_clr, conv_iValid, out_valid;
  logic [9:0]       rd_addr;
  logic [DWID-1:0]  rd_data1, rd_data2, rd_data3;
  logic [0:0]       k_idx;
  logic [DWID-1:0]  conv_iData1, conv_iData2, conv_iData3, conv_result, out_data;
  logic [12:0]      out_addr;

  conv_layer_sched #(
    .DATA_WIDTH(DWID), .F(3), .IMG_W(4), .IMG_H(4), .N_KERNEL(2),
    .PIPE_LAT(PL), .ADDR_W(10), .OADDR_W(13)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
    .k_idx(k_idx), .conv_clr(conv_clr), .conv_iValid(conv_iValid),
    .conv_iData1(conv_iData1), .conv_iData2(conv_iData2), .conv_iData3(conv_iData3),
    .conv_result(conv_result), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  // Feature RAM model: 1-cycle read latency, channel c holds index + c*0x100.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data1 <= 16'(rd_addr);
      rd_data2 <= 16'(rd_addr) + 16'h100;
      rd_data3 <= 16'(rd_addr) + 16'h200;
    end
  end

  logic [DWID-1:0] cpipe [PL];
  always @(posedge clk) begin
    cpipe[0] <= conv_iData1;
    for (int i = 1; i < PL; i++) cpipe[i] <= cpipe[i-1];
  end
  assign conv_result = cpipe[PL-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants plus event counters used by the directed steps.
  int   ov_total = 0, ov_k0 = 0, ov_k1 = 0, done_total = 0;
  logic prev_rd_en = 1'b0, prev_rst = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_rst) begin
      check("ivalid_past", conv_iValid, prev_rd_en);
      check("done_excl", done & (~busy | rd_en | conv_clr | conv_iValid), 0);
      check("busy_cover", (rd_en | conv_clr) & ~busy, 0);
    end
    if (out_valid === 1'b1) begin
      ov_total++;
      if (k_idx == 1'b0) ov_k0++;
      else ov_k1++;
    end
    if (done === 1'b1) done_total++;
    prev_rd_en = rd_en;
    prev_rst   = rst_n;
  end

  int n0 = 0;

  // NOTE: stimulus uses blocking assignments at negedge, well away from the sampling posedge.
  task automatic launch();
    start = 1'b1;
    n0    = tick;
  endtask

  task automatic wait_cyc(input int c);
    while (tick - n0 < c) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_k_idx"}, k_idx, 0);
    check({tag, "_clr"}, conv_clr, 0);
    check({tag, "_ivalid"}, conv_iValid, 0);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_oaddr"}, out_addr, 0);
  endtask

  task automatic check_out(input string tag, input int data, input int addr);
    check({tag, "_ov"}, out_valid, 1);
    check({tag, "_data"}, out_data, data);
    check({tag, "_addr"}, out_addr, addr);
  endtask

  int ov_base, k0_base, k1_base, done_base;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");

    // Abort mid-STREAM.
    launch();
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(8);
    check("t1_rd_en", rd_en, 1);
    check("t1_rd_addr", rd_addr, 6);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_idle("t1_abort");
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Full layer, with stray start pulses at cycles 5 and 30.
    ov_base = ov_total; k0_base = ov_k0; k1_base = ov_k1; done_base = done_total;
    launch();
    wait_cyc(1);
    start = 1'b0;
    check("t2_load_busy", busy, 1);
    check("t2_load_clr", conv_clr, 1);
    check("t2_load_k", k_idx, 0);
    check("t2_load_rd_en", rd_en, 0);
    wait_cyc(2);
    check("t2_c2_rd_en", rd_en, 1);
    check("t2_c2_addr", rd_addr, 0);
    check("t2_c2_clr", conv_clr, 0);
    wait_cyc(3);
    check("t2_c3_ivalid", conv_iValid, 1);
    check("t2_c3_d1", conv_iData1, 0);
    check("t2_c3_d2", conv_iData2, 16'h100);
    check("t2_c3_d3", conv_iData3, 16'h200);
    wait_cyc(5);
    start = 1'b1;
    wait_cyc(6);
    start = 1'b0;
    check("t4_c6_addr", rd_addr, 4);
    check("t4_c6_clr", conv_clr, 0);
    wait_cyc(17);
    check("t2_c17_rd_en", rd_en, 1);
    check("t2_c17_addr", rd_addr, 15);
    wait_cyc(18);
    check("t2_c18_rd_en", rd_en, 0);
    check("t2_c18_busy", busy, 1);
    wait_cyc(19);
    check_out("t3_c19", 10, 0);
    wait_cyc(20);
    check_out("t3_c20", 11, 1);
    wait_cyc(21);
    check("t3_c21_ov", out_valid, 0);
    wait_cyc(23);
    check_out("t3_c23", 14, 2);
    wait_cyc(24);
    check_out("t3_c24", 15, 3);
    wait_cyc(25);
    check("t2_c25_clr", conv_clr, 1);
    check("t2_c25_k", k_idx, 1);
    wait_cyc(30);
    start = 1'b1;
    wait_cyc(31);
    start = 1'b0;
    wait_cyc(43);
    check_out("t3_c43", 10, 4);
    wait_cyc(48);
    check_out("t3_c48", 15, 7);
    wait_cyc(49);
    check("t2_c49_done", done, 1);
    check("t2_c49_k", k_idx, 0);
    wait_cyc(50);
    check("t2_c50_busy", busy, 0);
    check("t2_c50_done", done, 0);
    check("t4_ov_total", ov_total - ov_base, 8);
    check("t4_ov_k0", ov_k0 - k0_base, 4);
    check("t4_ov_k1", ov_k1 - k1_base, 4);
    check("t4_done_cnt", done_total - done_base, 1);

    // Start held high: back-to-back layers, out_addr keeps counting.
    done_base = done_total;
    launch();
    wait_cyc(19);
    check_out("t5_c19", 10, 8);
    wait_cyc(49);
    check("t5_c49_done", done, 1);
    wait_cyc(50);
    check("t5_c50_busy", busy, 0);
    check("t5_c50_clr", conv_clr, 0);
    wait_cyc(51);
    check("t5_c51_clr", conv_clr, 1);
    check("t5_c51_busy", busy, 1);
    check("t5_c51_k", k_idx, 0);
    check("t5_c51_oaddr", out_addr, 16);
    wait_cyc(69);
    check_out("t5_c69", 10, 16);
    wait_cyc(81);
    check("t5_c81_k", k_idx, 1);
    check("t5_c81_rd_en", rd_en, 1);
    check("t5_c81_addr", rd_addr, 5);
    start = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_idle("t5_abort");
    check("t5_done_cnt", done_total - done_base, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Restart after an abort in kernel 1 begins again at kernel 0, out_addr 0.
    launch();
    wait_cyc(1);
    start = 1'b0;
    check("t6_load_k", k_idx, 0);
    check("t6_load_clr", conv_clr, 1);
    wait_cyc(2);
    check("t6_c2_addr", rd_addr, 0);
    wait_cyc(19);
    check_out("t6_c19", 10, 0);
    wait_cyc(49);
    check("t6_c49_done", done, 1);
    wait_cyc(50);
    check("t6_c50_busy", busy, 0);
    check("t6_c50_oaddr", out_addr, 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
